ysyx_22041412_lsu: RTL and testbench

// - Load/store unit directly downstream of the execute ALU: consumes the ALU result as the effective address and rs2 as store data.
// - Drives a 64-bit, doubleword-aligned memory port with a valid/ready request handshake and a response-valid return.
// - Loads: aligns, sign-/zero-extends and returns the data for writeback. Stores: generates byte masks.
// - Holds the pipeline via stall until the access completes.

---
 rtl/ysyx_22041412_lsu.sv | 183 ++++++++++++++++++
 tb/tb_ysyx_22041412_lsu.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_lsu.sv
// ysyx_22041412_lsu: load/store unit sitting directly behind the EX-stage ALU.
//
// Takes the ALU result as the effective address and rs2 as store data. It issues
// one access at a time on a 64-bit, doubleword-aligned memory port:
//   - requests use a valid/ready handshake;
//   - read data comes back on a response-valid strobe.
// Load data is aligned and sign- or zero-extended for writeback. Stores get a
// byte mask built from the access size and the byte offset.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   ex_valid, ld_en, st_en EX-stage valid and access type
//   func3                  RV64 size/sign code
//   addr, st_data          effective address and rs2 store data
//   stall                  holds upstream stages while an access is in flight
//   wb_valid               one-cycle completion pulse
//   ld_result              extended load data, held until the next completion
//   misalign               misaligned-access flag, valid with wb_valid
//   mem_req_valid/ready    request handshake
//   mem_we, mem_addr       request type and doubleword-aligned address
//   mem_wdata, mem_wmask   request write data and write byte mask
//   mem_rsp_valid/rdata    read response
//
// Optional feature: define YSYX_22041412_LSU_MISALIGN_CHECK_EN to trap
// misaligned accesses without touching memory. Otherwise misalign is tied to 0,
// and any bytes that fall past the doubleword boundary are dropped.
module ysyx_22041412_lsu #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic          ld_en,
  input  logic          st_en,
  input  logic [2:0]    func3,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] st_data,
  output logic          stall,
  output logic          wb_valid,
  output logic [DW-1:0] ld_result,
  output logic          misalign,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [7:0]    mem_wmask,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t        state, state_nx;
  logic          start;
  logic          mis_start;
  logic [AW-1:0] addr_q;
  logic [2:0]    func3_q;
  logic [DW-1:0] st_data_q;
  logic          is_store_q;
  logic [2:0]    off;
  logic [7:0]    size_mask;
  logic [DW-1:0] rsh;
  logic [DW-1:0] ld_ext;

  // A simultaneous load+store request is malformed and never starts an access.
  assign start = ex_valid & (ld_en ^ st_en);
  assign off   = addr_q[2:0];

`ifdef YSYX_22041412_LSU_MISALIGN_CHECK_EN
  logic misalign_q;

  always_comb begin
    mis_start = 1'b0;
    unique case (func3[1:0])
      2'b01:   mis_start = addr[0];
      2'b10:   mis_start = |addr[1:0];
      2'b11:   mis_start = |addr[2:0];
      default: mis_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (state == IDLE && start) begin
      misalign_q <= mis_start;
    end
  end

  assign misalign = (state == DONE) & misalign_q;
`else
  assign mis_start = 1'b0;
  assign misalign  = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start)         state_nx = mis_start ? DONE : REQ;
      REQ:  if (mem_req_ready) state_nx = is_store_q ? DONE : RESP;
      RESP: if (mem_rsp_valid) state_nx = DONE;
      DONE:                    state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // Load alignment and extension. Shifting right leaves zeros above the
  // doubleword boundary, so an access that straddles it is simply truncated.
  always_comb begin
    rsh    = mem_rdata >> {off, 3'b000};
    ld_ext = rsh;
    unique case (func3_q)
      3'b000:  ld_ext = {{(DW-8){rsh[7]}},   rsh[7:0]};
      3'b001:  ld_ext = {{(DW-16){rsh[15]}}, rsh[15:0]};
      3'b010:  ld_ext = {{(DW-32){rsh[31]}}, rsh[31:0]};
      3'b100:  ld_ext = {{(DW-8){1'b0}},     rsh[7:0]};
      3'b101:  ld_ext = {{(DW-16){1'b0}},    rsh[15:0]};
      3'b110:  ld_ext = {{(DW-32){1'b0}},    rsh[31:0]};
      default: ld_ext = rsh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      func3_q    <= '0;
      st_data_q  <= '0;
      is_store_q <= 1'b0;
      ld_result  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        addr_q     <= addr;
        func3_q    <= func3;
        st_data_q  <= st_data;
        is_store_q <= st_en;
        if (mis_start && ld_en) begin
          ld_result <= '0;
        end
      end
      if (state == RESP && mem_rsp_valid) begin
        ld_result <= ld_ext;
      end
    end
  end

  always_comb begin
    size_mask = 8'h01;
    unique case (func3_q[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Request fields are driven only while the request is presented, so the
  // port reads as all-zero at every other time.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    if (state == REQ) begin
      mem_req_valid = 1'b1;
      mem_we        = is_store_q;
      mem_addr      = {addr_q[AW-1:3], 3'b000};
      if (is_store_q) begin
        mem_wdata = st_data_q << {off, 3'b000};
        mem_wmask = size_mask << off;
      end
    end
  end

  assign stall    = ((state == IDLE) & start) | (state == REQ) | (state == RESP);
  assign wb_valid = (state == DONE);

endmodule

// File: tb/tb_ysyx_22041412_lsu.sv
module tb_ysyx_22041412_lsu;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ld_en;
  logic        st_en;
  logic [2:0]  func3;
  logic [63:0] addr;
  logic [63:0] st_data;
  logic        stall;
  logic        wb_valid;
  logic [63:0] ld_result;
  logic        misalign;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;

  typedef struct {
    logic [63:0] ld_result;
    logic        misalign;
  } exp_t;

  exp_t        sb[$];
  int          n_assert;
  int          n_fail;
  logic [63:0] last_ld;

  ysyx_22041412_lsu #(.AW(64), .DW(64)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ld_en(ld_en), .st_en(st_en),
    .func3(func3), .addr(addr), .st_data(st_data), .stall(stall),
    .wb_valid(wb_valid), .ld_result(ld_result), .misalign(misalign),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [7:0] model_mask(input logic [2:0] f3, input int off);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++)
      if (i >= off && i < off + size_of(f3)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] d, input int off);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++)
      if (i >= off) w[i*8 +: 8] = d[(i-off)*8 +: 8];
    return w;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [2:0] f3, input int off);
    logic [63:0] v;
    int sz;
    v  = '0;
    sz = size_of(f3);
    for (int j = 0; j < sz; j++)
      if (off + j < 8) v[j*8 +: 8] = rd[(off+j)*8 +: 8];
    if (!f3[2] && sz < 8 && v[sz*8-1])
      for (int j = sz*8; j < 64; j++) v[j] = 1'b1;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete access: the bench plays the memory with a ready delay r and
  // a response delay s, and scrambles the LSU inputs while it is busy.
  task automatic access(input logic st, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] d, input logic [63:0] rd, input int r, input int s);
    exp_t e;
    int   off;
    bit   mis;
    off = int'(a[2:0]);
    mis = 1'b0;
`ifdef YSYX_22041412_LSU_MISALIGN_CHECK_EN
    mis = (off % size_of(f3)) != 0;
`endif
    e.misalign  = mis;
    e.ld_result = st ? last_ld : (mis ? 64'h0 : model_load(rd, f3, off));
    sb.push_back(e);
    last_ld = e.ld_result;

    ex_valid = 1'b1; ld_en = !st; st_en = st; func3 = f3; addr = a; st_data = d;
    @(negedge clk);
    chk("start_stall", stall, 1);
    chk("start_noreq", mem_req_valid, 0);
    tick();
    ex_valid = 1'b1; ld_en = 1'b1; st_en = 1'b0; addr = ~a; st_data = ~d; func3 = ~f3;
    if (!mis) begin
      for (int k = 0; k <= r; k++) begin
        mem_req_ready = (k == r);
        @(negedge clk);
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_addr, {a[63:3], 3'b000});
        chk("req_we", mem_we, st);
        chk("req_wmask", mem_wmask, st ? model_mask(f3, off) : 8'h00);
        chk("req_wdata", mem_wdata, st ? model_wdata(d, off) : 64'h0);
        chk("req_stall", stall, 1);
        chk("req_nowb", wb_valid, 0);
        tick();
      end
      mem_req_ready = 1'b0;
      if (!st) begin
        for (int k = 0; k <= s; k++) begin
          mem_rsp_valid = (k == s);
          mem_rdata     = (k == s) ? rd : ~rd;
          @(negedge clk);
          chk("resp_stall", stall, 1);
          chk("resp_noreq", mem_req_valid, 0);
          chk("resp_nowb", wb_valid, 0);
          tick();
        end
        mem_rsp_valid = 1'b0;
      end
    end
    ex_valid = 1'b0; ld_en = 1'b0;
    @(negedge clk);
    chk("done_wb", wb_valid, 1);
    chk("done_stall", stall, 0);
    chk("done_noreq", mem_req_valid, 0);
    if (wb_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("ld_result", ld_result, e.ld_result);
      chk("misalign", misalign, e.misalign);
    end
    tick();
    @(negedge clk);
    chk("wb_one_cycle", wb_valid, 0);
    chk("ld_result_hold", ld_result, last_ld);
    tick();
  endtask

  initial begin
    n_assert = 0; n_fail = 0; last_ld = '0;
    rst = 1'b1; ex_valid = 1'b0; ld_en = 1'b0; st_en = 1'b0; func3 = '0;
    addr = '0; st_data = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_wb", wb_valid, 0);
    chk("rst_ld_result", ld_result, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_req", mem_req_valid, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wmask", mem_wmask, 0);
    tick();
    rst = 1'b0;
    tick();

    // ld, lb, lbu
    access(1'b0, 3'b011, 64'h8000_0008, 64'h0, 64'h1122_3344_5566_7788, 0, 0);
    chk("ld_const", ld_result, 64'h1122_3344_5566_7788);
    access(1'b0, 3'b000, 64'h8000_0003, 64'h0, 64'h1122_3344_8066_7788, 0, 0);
    chk("lb_const", ld_result, 64'hFFFF_FFFF_FFFF_FF80);
    access(1'b0, 3'b100, 64'h8000_0003, 64'h0, 64'h1122_3344_8066_7788, 0, 0);
    chk("lbu_const", ld_result, 64'h0000_0000_0000_0080);
    // sh at offset 6 (mask 0xC0, data in [63:48])
    access(1'b1, 3'b001, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'h0, 0, 0);
    // Store held off by ready low for 5 cycles
    access(1'b1, 3'b010, 64'h8000_0010, 64'h1234_5678_9ABC_DEF0, 64'h0, 5, 0);
    // Slow response; lhu; then ld with func3=111
    access(1'b0, 3'b101, 64'h8000_000A, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0, 3);
    access(1'b0, 3'b111, 64'h8000_0018, 64'h0, 64'h8877_6655_4433_2211, 2, 1);
    // lw at offset 2 (misaligned)
    access(1'b0, 3'b010, 64'h8000_0002, 64'h0, 64'h1122_9944_5566_7788, 0, 0);
`ifndef YSYX_22041412_LSU_MISALIGN_CHECK_EN
    chk("lw_mis_const", ld_result, 64'hFFFF_FFFF_9944_5566);
`endif
    // Straddling accesses: truncated at the doubleword boundary
    access(1'b0, 3'b110, 64'h8000_000E, 64'h0, 64'hF0E1_D2C3_B4A5_9687, 0, 0);
    access(1'b1, 3'b011, 64'h8000_0005, 64'h0102_0304_0506_0708, 64'h0, 1, 0);

    // ld_en and st_en together: ignored
    ex_valid = 1'b1; ld_en = 1'b1; st_en = 1'b1; func3 = 3'b011; addr = 64'h8000_0040;
    @(negedge clk);
    chk("both_nostall", stall, 0);
    tick();
    ex_valid = 1'b0; ld_en = 1'b0; st_en = 1'b0;
    @(negedge clk);
    chk("both_noreq", mem_req_valid, 0);
    chk("both_nowb", wb_valid, 0);
    tick();

    // Reset while waiting for a load response, then a late response
    ex_valid = 1'b1; ld_en = 1'b1; func3 = 3'b011; addr = 64'h8000_0020;
    tick();
    ex_valid = 1'b0; ld_en = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("rstmid_resp_stall", stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h5555_AAAA_5555_AAAA;
    @(negedge clk);
    chk("rstmid_wb", wb_valid, 0);
    chk("rstmid_stall", stall, 0);
    chk("rstmid_req", mem_req_valid, 0);
    chk("rstmid_ld_result", ld_result, 0);
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_late_wb", wb_valid, 0);
    chk("rstmid_late_ld", ld_result, 0);
    last_ld = '0;
    tick();
    access(1'b0, 3'b001, 64'h8000_0024, 64'h0, 64'h0000_9876_0000_0000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
